// File: rtl/winograd_itrans.sv
`default_nettype none
// ============================================================================
// Module   : winograd_itrans
// Purpose  : Winograd F(4,3) input-transform stage. Collects one 6x6 input
//            tile row by row, computes V = BT * d * B with shift/add logic
//            only, and presents it together with the tile x/y index. In
//            bypass mode the tile is passed through unchanged, sign-extended
//            to OUT_W bits.
// Macro    : WINO_ITRANS_SAT_EN - when defined, each transformed output
//            saturates to the signed OUT_W range. When undefined, each output
//            keeps its low OUT_W bits (two's-complement wrap) and no
//            saturation logic exists.
// Ports    : clk             rising-edge clock
//            reset           synchronous, active-low reset
//            in_valid        in_row holds a valid tile row
//            in_ready        stage accepts a row this cycle (state LOAD)
//            in_row[0:5]     signed pixels of the current row
//            in_x_index      tile x index, captured with row 0
//            in_y_index      tile y index, captured with row 0
//            in_size_type    0 = bypass, 1 = transform, captured with row 0
//            data_tile_o     signed transformed 6x6 tile
//            data_valid_o    tile and indices valid
//            data_ready_i    downstream accepts the presented tile
//            data_x_index_o  x index of the presented tile
//            data_y_index_o  y index of the presented tile
// Revision : 1.0 - initial release
// ============================================================================
module winograd_itrans #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_row [0:5],
  input  logic [8:0]               in_x_index,
  input  logic [8:0]               in_y_index,
  input  logic                     in_size_type,
  output logic signed [OUT_W-1:0]  data_tile_o [0:5][0:5],
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic [8:0]               data_x_index_o,
  output logic [8:0]               data_y_index_o
);

  // Full precision after the first pass (BT*d) and after the second (*B).
  localparam int TW = DATA_W + 4;
  localparam int FW = DATA_W + 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] row_cnt;
  logic       mode;
  logic [8:0] cap_x;
  logic [8:0] cap_y;

  logic signed [DATA_W-1:0] tile_d  [0:5][0:5];
  logic signed [TW-1:0]     tmp     [0:5][0:5];
  logic signed [TW-1:0]     t1_val  [0:5][0:5];
  logic signed [OUT_W-1:0]  t2_val  [0:5][0:5];
  logic signed [OUT_W-1:0]  byp_val [0:5][0:5];

  // One row of BT applied to a 6-element vector: sum_k BT[r][k] * a_k.
  // Coefficients are 0, +-1, +-2, +-4, +-5, built from shifts and adds.
  function automatic logic signed [FW-1:0] bt_mac(
    input int                   r,
    input logic signed [FW-1:0] a0,
    input logic signed [FW-1:0] a1,
    input logic signed [FW-1:0] a2,
    input logic signed [FW-1:0] a3,
    input logic signed [FW-1:0] a4,
    input logic signed [FW-1:0] a5
  );
    logic signed [FW-1:0] s;
    case (r)
      0:       s = (a0 <<< 2) - (a2 <<< 2) - a2 + a4;
      1:       s = a3 + a4 - ((a1 + a2) <<< 2);
      2:       s = a4 - a3 + ((a1 - a2) <<< 2);
      3:       s = a4 - a2 + ((a3 - a1) <<< 1);
      4:       s = a4 - a2 + ((a1 - a3) <<< 1);
      5:       s = (a1 <<< 2) - (a3 <<< 2) - a3 + a5;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign in_ready = (state == LOAD);

  for (genvar i = 0; i < 6; i++) begin : g_row
    for (genvar j = 0; j < 6; j++) begin : g_col
      // First pass works down column j of the input tile. The result fits
      // in TW bits, so the narrowing cast drops only sign copies.
      assign t1_val[i][j] = TW'(bt_mac(i,
                                       FW'(tile_d[0][j]), FW'(tile_d[1][j]),
                                       FW'(tile_d[2][j]), FW'(tile_d[3][j]),
                                       FW'(tile_d[4][j]), FW'(tile_d[5][j])));

      assign byp_val[i][j] = OUT_W'(tmp[i][j]);

      // Second pass: (tmp*B)[i][j] = sum_k tmp[i][k] * BT[j][k].
`ifdef WINO_ITRANS_SAT_EN
      if (FW > OUT_W) begin : g_sat
        localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
        localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
        logic signed [FW-1:0] full;
        logic                 ovf;
        assign full = bt_mac(j,
                             FW'(tmp[i][0]), FW'(tmp[i][1]), FW'(tmp[i][2]),
                             FW'(tmp[i][3]), FW'(tmp[i][4]), FW'(tmp[i][5]));
        // Out of range when the bits above the OUT_W sign bit are not all
        // copies of the true sign.
        assign ovf = (full[FW-1:OUT_W-1] != {(FW-OUT_W+1){full[FW-1]}});
        assign t2_val[i][j] = ovf ? (full[FW-1] ? SAT_MIN : SAT_MAX)
                                  : full[OUT_W-1:0];
      end else begin : g_ext
        assign t2_val[i][j] = OUT_W'(bt_mac(j,
                                FW'(tmp[i][0]), FW'(tmp[i][1]), FW'(tmp[i][2]),
                                FW'(tmp[i][3]), FW'(tmp[i][4]), FW'(tmp[i][5])));
      end
`else
      // Cast either wraps to the low OUT_W bits or sign-extends.
      assign t2_val[i][j] = OUT_W'(bt_mac(j,
                              FW'(tmp[i][0]), FW'(tmp[i][1]), FW'(tmp[i][2]),
                              FW'(tmp[i][3]), FW'(tmp[i][4]), FW'(tmp[i][5])));
`endif
    end
  end

  // Datapath storage: no reset needed, contents are only consumed after a
  // full tile has been loaded.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      for (int c = 0; c < 6; c++) begin
        tile_d[row_cnt][c] <= in_row[c];
      end
    end
    if (state == T1) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          tmp[i][j] <= mode ? t1_val[i][j] : TW'(tile_d[i][j]);
        end
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= LOAD;
      row_cnt        <= 3'd0;
      mode           <= 1'b0;
      cap_x          <= 9'd0;
      cap_y          <= 9'd0;
      data_valid_o   <= 1'b0;
      data_x_index_o <= 9'd0;
      data_y_index_o <= 9'd0;
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          data_tile_o[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (row_cnt == 3'd0) begin
              cap_x <= in_x_index;
              cap_y <= in_y_index;
              mode  <= in_size_type;
            end
            if (row_cnt == 3'd5) begin
              row_cnt <= 3'd0;
              state   <= T1;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        T1: begin
          state <= T2;
        end
        T2: begin
          for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
              data_tile_o[i][j] <= mode ? t2_val[i][j] : byp_val[i][j];
            end
          end
          data_valid_o   <= 1'b1;
          data_x_index_o <= cap_x;
          data_y_index_o <= cap_y;
          state          <= OUT;
        end
        OUT: begin
          if (data_ready_i) begin
            data_valid_o <= 1'b0;
            state        <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_winograd_itrans.sv
`default_nettype none
// ============================================================================
// Module   : tb_winograd_itrans
// Purpose  : Self-checking bench for winograd_itrans (DATA_W = 10). Expected
//            tiles come from a plain integer matrix model V = BT*d*BT^T,
//            narrowed by saturation or wrap depending on WINO_ITRANS_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_winograd_itrans;

  localparam int DW = 10;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_row [0:5];
  logic [8:0]           in_x_index = 9'd0;
  logic [8:0]           in_y_index = 9'd0;
  logic                 in_size_type = 1'b0;
  logic signed [OW-1:0] data_tile_o [0:5][0:5];
  logic                 data_valid_o;
  logic                 data_ready_i = 1'b0;
  logic [8:0]           data_x_index_o;
  logic [8:0]           data_y_index_o;

  int checks = 0;
  int errors = 0;

  int d_m   [0:5][0:5];
  int exp_t [0:5][0:5];
  int bt    [0:5][0:5] = '{'{4,  0, -5,  0, 1, 0},
                           '{0, -4, -4,  1, 1, 0},
                           '{0,  4, -4, -1, 1, 0},
                           '{0, -2, -1,  2, 1, 0},
                           '{0,  2, -1, -2, 1, 0},
                           '{0,  4,  0, -5, 0, 1}};

  winograd_itrans #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_row         (in_row),
    .in_x_index     (in_x_index),
    .in_y_index     (in_y_index),
    .in_size_type   (in_size_type),
    .data_tile_o    (data_tile_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .data_x_index_o (data_x_index_o),
    .data_y_index_o (data_y_index_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: matrix products with plain integers, then narrowing.
  task automatic model(input bit mode);
    longint t [0:5][0:5];
    longint v;
    logic signed [OW-1:0] w;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        t[i][j] = 0;
        if (mode) for (int k = 0; k < 6; k++) t[i][j] += bt[i][k] * d_m[k][j];
        else t[i][j] = d_m[i][j];
      end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        v = 0;
        if (mode) for (int k = 0; k < 6; k++) v += t[i][k] * bt[j][k];
        else v = t[i][j];
`ifdef WINO_ITRANS_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        exp_t[i][j] = int'(v);
`else
        w = v[OW-1:0];
        exp_t[i][j] = int'(w);
`endif
      end
  endtask

  task automatic check_tile(input string tag);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        check($sformatf("%s_t%0d%0d", tag, i, j), data_tile_o[i][j], exp_t[i][j]);
  endtask

  // Sends d_m as a tile starting at a negedge where the DUT is in LOAD,
  // then checks the two-edge latency, the tile and the indices.
  task automatic send_tile(input string tag, input bit mode, input int x, input int y);
    model(mode);
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      check({tag, "_rdy"}, in_ready, 1);
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) in_row[c] = DW'(d_m[r][c]);
      if (r == 0) begin
        in_x_index   = 9'(x);
        in_y_index   = 9'(y);
        in_size_type = mode;
      end else begin
        in_x_index   = 9'($urandom);
        in_y_index   = 9'($urandom);
        in_size_type = ~mode;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    check({tag, "_v0"}, data_valid_o, 0);
    @(negedge clk);
    check({tag, "_v1"}, data_valid_o, 0);
    @(negedge clk);
    check({tag, "_vld"}, data_valid_o, 1);
    check({tag, "_x"}, data_x_index_o, x);
    check({tag, "_y"}, data_y_index_o, y);
    check_tile(tag);
  endtask

  task automatic release_tile(input string tag);
    data_ready_i = 1'b1;
    @(negedge clk);
    data_ready_i = 1'b0;
    check({tag, "_vfall"}, data_valid_o, 0);
    check({tag, "_rdyback"}, in_ready, 1);
  endtask

  task automatic set_bypass();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) d_m[i][j] = 6 * i + j;
  endtask

  initial begin
    int b0 [0:5] = '{4, 0, -5, 0, 1, 0};
    int p;
    for (int c = 0; c < 6; c++) in_row[c] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", data_valid_o, 0);
    check("rst_ready", in_ready, 1);
    check("rst_x", data_x_index_o, 0);
    check("rst_y", data_y_index_o, 0);
    check("rst_t00", data_tile_o[0][0], 0);
    check("rst_t55", data_tile_o[5][5], 0);
    reset = 1'b1;

    // Bypass
    set_bypass();
    send_tile("byp", 1'b0, 3, 7);
    release_tile("byp");

    // Impulse
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d_m[i][j] = 0;
    d_m[2][2] = 1;
    send_tile("imp", 1'b1, 1, 2);
    check("imp_11", data_tile_o[1][1], 16);
    check("imp_13", data_tile_o[1][3], 4);
    check("imp_34", data_tile_o[3][4], 1);
    for (int i = 0; i < 6; i++) check($sformatf("imp_col5_%0d", i), data_tile_o[i][5], 0);
    release_tile("imp");

    // All ones
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) d_m[i][j] = 1;
    send_tile("one", 1'b1, 511, 0);
    check("one_11", data_tile_o[1][1], 36);
    check("one_00", data_tile_o[0][0], 0);

    // Backpressure on the all-ones tile; in_valid pulses must be dropped.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      for (int c = 0; c < 6; c++) in_row[c] = DW'($urandom);
      check("bp_valid", data_valid_o, 1);
      check("bp_ready", in_ready, 0);
      check("bp_x", data_x_index_o, 511);
      check("bp_y", data_y_index_o, 0);
      check("bp_t11", data_tile_o[1][1], 36);
      check("bp_t34", data_tile_o[3][4], 0);
    end
    in_valid = 1'b0;
    release_tile("bp");
    // Row counter must be unaffected by the dropped pulses.
    set_bypass();
    send_tile("bpnext", 1'b0, 5, 6);
    release_tile("bpnext");

    // Overflow
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        p = b0[i] * b0[j];
        d_m[i][j] = (p > 0) ? 511 : ((p < 0) ? -511 : 0);
      end
    send_tile("ovf", 1'b1, 8, 9);
`ifdef WINO_ITRANS_SAT_EN
    check("ovf_00", data_tile_o[0][0], 32767);
`else
    check("ovf_00", data_tile_o[0][0], -14436);
`endif
    release_tile("ovf");

    // Reset in the middle of a load
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_size_type = 1'b1;
      for (int c = 0; c < 6; c++) in_row[c] = DW'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mrst_ready", in_ready, 1);
    check("mrst_valid", data_valid_o, 0);
    check("mrst_t23", data_tile_o[2][3], 0);
    set_bypass();
    send_tile("mrst", 1'b0, 3, 7);
    release_tile("mrst");

    // Randomized tiles with random hold times
    for (int n = 0; n < 10; n++) begin
      bit m;
      int hold;
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) d_m[i][j] = int'($urandom_range(0, 1023)) - 512;
      send_tile($sformatf("rnd%0d", n), m, int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)));
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("rnd_hold_valid", data_valid_o, 1);
        check("rnd_hold_t00", data_tile_o[0][0], exp_t[0][0]);
      end
      release_tile("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
